// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the TX frame scheduler: FSM encoding, preamble/SFD
// bytes and the layout of the header that precedes each frame in the ring.
package tx_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WAIT_TS,
    PREAMBLE,
    DATA,
    IFG
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 8;

  localparam logic [1:0] HDR_LEN_OFS    = 2'd0;
  localparam logic [1:0] HDR_TS_HI_OFS  = 2'd1;
  localparam logic [1:0] HDR_TS_MID_OFS = 2'd2;
  localparam logic [1:0] HDR_TS_LO_OFS  = 2'd3;
  localparam int         HDR_WORDS      = 4;

  // Payload occupies ceil(len/2) 16-bit words.
  function automatic logic [10:0] payload_words(input logic [10:0] len);
    logic [11:0] sum;
    sum = {1'b0, len} + 12'd1;
    return sum[11:1];
  endfunction

endpackage

// File: rtl/tx_ts_compare.sv
// Registered launch-time check: high one clock after now >= ts, or when ts is
// zero (meaning "send as soon as possible").
module tx_ts_compare (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [47:0] ts_i,
  input  logic [47:0] now_i,
  output logic        ge_o
);

  logic ge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ge_q <= 1'b0;
    end else begin
      ge_q <= (ts_i == 48'd0) || (now_i >= ts_i);
    end
  end

  assign ge_o = ge_q;

endmodule

// File: rtl/tx_frame_scheduler.sv
// Pulls timestamped frame records out of a TX ring buffer and plays them onto
// GMII with preamble/SFD and inter-frame gap, returning the read pointer.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int IFG_BYTES = 12,
  parameter int MIN_LEN   = 14,
  parameter int MAX_LEN   = 1522
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              tx_enable,
  input  logic [47:0]       global_counter,
  input  logic [ADDR_W-1:0] mem_wr_ptr,
  output logic [ADDR_W-1:0] mem_rd_ptr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [15:0]       mem_rd_data,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic              tx_busy,
  output logic              len_err,
  output logic [31:0]       frame_cnt
);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_snap_q, wr_snap_d;
  logic [10:0]       len_q, len_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [15:0]       ts_hi_q, ts_hi_d, ts_mid_q, ts_mid_d, ts_lo_q, ts_lo_d;
  logic [7:0]        txd_q, txd_d;
  logic              tx_en_q, tx_en_d;
  logic              len_err_q, len_err_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;

  logic [10:0]       rx_len;
  logic              len_bad;
  logic [47:0]       ts_cmp;
  logic              ts_ready;
  logic [ADDR_W-1:0] next_rec;

  assign rx_len   = mem_rd_data[10:0];
  assign len_bad  = (rx_len < 11'(MIN_LEN)) || (rx_len > 11'(MAX_LEN));
  assign next_rec = rd_ptr_q + ADDR_W'(HDR_WORDS) + ADDR_W'(payload_words(len_q));

  // The low timestamp word is fed straight from memory on the last header
  // read so the registered compare is ready on the first WAIT_TS clock.
  assign ts_cmp = (state_q == HDR) ? {ts_hi_q, ts_mid_q, mem_rd_data}
                                   : {ts_hi_q, ts_mid_q, ts_lo_q};

  tx_ts_compare u_ts_compare (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .ts_i  (ts_cmp),
    .now_i (global_counter),
    .ge_o  (ts_ready)
  );

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_addr_d   = rd_addr_q;
    wr_snap_d   = wr_snap_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ts_hi_d     = ts_hi_q;
    ts_mid_d    = ts_mid_q;
    ts_lo_d     = ts_lo_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    len_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (tx_enable && (mem_wr_ptr != rd_ptr_q)) begin
          wr_snap_d = mem_wr_ptr;
          rd_addr_d = rd_ptr_q + ADDR_W'(1);
          cnt_d     = 11'd0;
          state_d   = HDR;
        end
      end
      HDR: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q[1:0] != HDR_TS_LO_OFS) rd_addr_d = rd_addr_q + ADDR_W'(1);
        case (cnt_q[1:0])
          HDR_LEN_OFS: begin
            len_d = rx_len;
            // Bad length: drop everything queued up to the sampled write pointer.
            if (len_bad) begin
              len_err_d = 1'b1;
              rd_ptr_d  = wr_snap_q;
              rd_addr_d = wr_snap_q;
              state_d   = IDLE;
            end
          end
          HDR_TS_HI_OFS:  ts_hi_d  = mem_rd_data;
          HDR_TS_MID_OFS: ts_mid_d = mem_rd_data;
          HDR_TS_LO_OFS: begin
            ts_lo_d = mem_rd_data;
            state_d = WAIT_TS;
          end
        endcase
      end
      WAIT_TS: begin
        if (ts_ready) begin
          cnt_d   = 11'd0;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        tx_en_d = 1'b1;
        cnt_d   = cnt_q + 11'd1;
        txd_d   = PREAMBLE_BYTE;
        if (cnt_q == 11'(PREAMBLE_LEN - 1)) begin
          txd_d   = SFD_BYTE;
          cnt_d   = 11'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_en_d = 1'b1;
        cnt_d   = cnt_q + 11'd1;
        txd_d   = cnt_q[0] ? mem_rd_data[7:0] : mem_rd_data[15:8];
        // Read data lags the address by one clock, so stepping the address on
        // the high byte lands the next word exactly when it is needed.
        if (!cnt_q[0]) rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (cnt_q == len_q - 11'd1) begin
          rd_ptr_d    = next_rec;
          rd_addr_d   = next_rec;
          frame_cnt_d = frame_cnt_q + 32'd1;
          cnt_d       = 11'd0;
          state_d     = IFG;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == 11'(IFG_BYTES - 1)) begin
          cnt_d   = 11'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      rd_addr_q   <= '0;
      wr_snap_q   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ts_hi_q     <= '0;
      ts_mid_q    <= '0;
      ts_lo_q     <= '0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_addr_q   <= rd_addr_d;
      wr_snap_q   <= wr_snap_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ts_hi_q     <= ts_hi_d;
      ts_mid_q    <= ts_mid_d;
      ts_lo_q     <= ts_lo_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      len_err_q   <= len_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign mem_rd_ptr  = rd_ptr_q;
  assign mem_rd_addr = rd_addr_q;
  assign gmii_txd    = txd_q;
  assign gmii_tx_en  = tx_en_q;
  assign tx_busy     = (state_q != IDLE);
  assign len_err     = len_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: TX memory word-address and pointer width; 4096-word ring.
REQ-002 SHALL have parameter IFG_BYTES, default 12: inter-frame gap, in clocks.
REQ-003 SHALL have parameter MIN_LEN, default 14: minimum legal frame length, in bytes.
REQ-004 SHALL have parameter MAX_LEN, default 1522: maximum legal frame length, in bytes.
REQ-005 SHALL have port sys_clk, input, 1: the single 125 MHz clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port tx_enable, input, 1: permits new frames to start.
REQ-008 SHALL have port global_counter, input, 48: free-running timestamp.
REQ-009 SHALL have port mem_wr_ptr, input, ADDR_W: producer write pointer.
REQ-010 SHALL have port mem_rd_ptr, output, ADDR_W: consumer read pointer, returned to the producer.
REQ-011 SHALL have port mem_rd_addr, output, ADDR_W: TX memory read address.
REQ-012 SHALL have port mem_rd_data, input, 16: TX memory read data, valid 1 clock after its address.
REQ-013 SHALL have port gmii_txd, output, 8: GMII transmit byte.
REQ-014 SHALL have port gmii_tx_en, output, 1: GMII transmit enable.
REQ-015 SHALL have port tx_busy, output, 1: high whenever the FSM is not IDLE.
REQ-016 SHALL have port len_err, output, 1: one-clock pulse on an illegal frame length.
REQ-017 SHALL have port frame_cnt, output, 32: count of transmitted frames.

Function
REQ-018 Frame record layout SHALL be: word0[10:0] = length in bytes, FCS included; words 1-3 = timestamp[47:32], [31:16], [15:0]; then ceil(len/2) payload words.
REQ-019 Ring SHALL be empty when mem_rd_ptr == mem_wr_ptr; all pointer and address arithmetic SHALL be modulo 2^ADDR_W.
REQ-020 FSM states SHALL be IDLE, HDR, WAIT_TS, PREAMBLE, DATA, IFG.
REQ-021 IDLE -> HDR SHALL occur when tx_enable=1 and the ring is non-empty; mem_wr_ptr is sampled only in IDLE.
REQ-022 HDR SHALL read words rd_ptr+0..3, then go to WAIT_TS.
REQ-023 In HDR, len<MIN_LEN or len>MAX_LEN SHALL pulse len_err for one clock, set mem_rd_ptr to the sampled mem_wr_ptr (flush), return to IDLE, and transmit nothing.
REQ-024 WAIT_TS SHALL leave when timestamp==0 or global_counter>=timestamp (unsigned 48-bit compare); a timestamp already in the past SHALL send immediately.
REQ-025 PREAMBLE SHALL output 7 bytes 0x55, then 1 byte 0xD5, with gmii_tx_en=1.
REQ-026 DATA SHALL output exactly len bytes; within each word [15:8] goes first, then [7:0].
REQ-027 For odd len, the final byte SHALL be the last word's [15:8], and its [7:0] SHALL be discarded.
REQ-028 DATA SHALL issue memory reads so the byte stream has no bubbles, given the 1-clock read latency.
REQ-029 IFG SHALL hold gmii_tx_en=0 and gmii_txd=0x00 for IFG_BYTES clocks, then go to IDLE.
REQ-030 On the last DATA byte, mem_rd_ptr SHALL advance to the start address + 4 + ceil(len/2), and frame_cnt SHALL increment, wrapping at 2^32.
REQ-031 With timestamp 0, gmii_tx_en SHALL rise exactly 7 clocks after the IDLE cycle that detects non-empty.
REQ-032 gmii_txd and gmii_tx_en SHALL be registered outputs.
REQ-033 Deasserting tx_enable mid-frame SHALL NOT truncate the frame; it only blocks the next IDLE exit.
REQ-034 A change of mem_wr_ptr while not in IDLE SHALL be ignored until the next IDLE.

Reset
REQ-035 sys_rst SHALL be sampled on sys_clk only (synchronous).
REQ-036 When sys_rst=1, the next clock SHALL force: state=IDLE, mem_rd_ptr=0, mem_rd_addr=0, gmii_txd=0x00, gmii_tx_en=0, tx_busy=0, len_err=0, frame_cnt=0.
REQ-037 Reset asserted mid-frame SHALL drop gmii_tx_en on the next clock, with no IFG.

Structure
REQ-038 The shared package SHALL hold the FSM state encoding, the PREAMBLE_BYTE (0x55) and SFD_BYTE (0xD5) constants, and the header word offsets.
REQ-039 One sub-module, tx_ts_compare, SHALL be used: a registered 48-bit ">=" compare with zero-bypass.
REQ-040 Everything other than tx_ts_compare SHALL be a single FSM module.

Verification
REQ-041 Scenario: rd=0, len=60, ts=0, wr_ptr=0x022 -> 8 preamble/SFD bytes, then 60 payload bytes, 12 IFG clocks; rd_ptr=0x022; frame_cnt=1.
REQ-042 Scenario: len=61, wr_ptr=0x023 -> 61 bytes transmitted; low byte of word 0x022 unused; rd_ptr=0x023.
REQ-043 Scenario: ts=0x000000000100, global_counter starting at 0x80 -> gmii_tx_en stays 0 until counter>=0x100, then the preamble starts.
REQ-044 Scenario: frame at 0xFF0, len=64, wr_ptr=0x014 -> addresses wrap 0xFFF->0x000; rd_ptr=0x014.
REQ-045 Scenario: len=8, wr_ptr=0x030 -> one len_err pulse; gmii_tx_en never rises; rd_ptr=0x030.
REQ-046 Scenario: sys_rst at the 20th DATA byte -> gmii_tx_en=0 the next clock; rd_ptr=0; frame_cnt=0.
